mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle main controller for the RISC-V subset datapath: R-type add/sub/or/and, lw, sw, beq.
- Sequences fetch, decode, execute, memory and writeback. Drives the datapath mux selects and write enables.
- Drives the 2-bit ALUOp consumed by the ALU-control decoder: 00 = add, 01 = sub, 10 = decode from funct.
- Talks to a shared instruction/data memory through a req/ready handshake. Counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
RESET_PC_HOLD, 1, idle cycles after reset deassert before the first fetch (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instruction register bits [6:0], valid from DECODE onward
zero  in  1  ALU zero flag, combinational from the current ALU operation
mem_ready  in  1  memory completes the current access this cycle
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
ALUSrcA  out  2  00 PC, 01 OldPC, 10 regA
ALUSrcB  out  2  00 regB, 01 const 4, 10 immediate
ResultSrc  out  2  00 ALUOut register, 01 memory data register, 10 ALU result
IorD  out  1  memory address select: 0 PC, 1 ALUOut
MemRead  out  1  read request, held until mem_ready
MemWrite  out  1  write request, held until mem_ready
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  load PC from Result
RegWrite  out  1  register file write
state_o  out  4  current state encoding (debug)
halt  out  1  illegal opcode trap, sticky
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, hold counter=RESET_PC_HOLD, retired=0, halt=0.
  - All outputs 0.
- Structure:
  - State register plus small counters are sequential. Outputs are a combinational decode of state, plus mem_ready/zero where noted.
  - Outputs not listed for a state are 0.
- IDLE: all outputs 0. Decrement hold each cycle; go to FETCH when hold reaches 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00: computes the branch target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 1100011 -> BRANCH
    - any other value -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD:
  - MemRead=1, IorD=1.
  - Wait on mem_ready; go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1. Retire, then go to FETCH.
- MEMWR:
  - MemWrite=1, IorD=1.
  - Wait on mem_ready. On mem_ready=1, retire and go to FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Retire, then go to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=zero.
  - Retire, then go to FETCH.
- TRAP: halt=1. All other outputs 0. Stays in TRAP until rst_n=0; no retire.
- Retire: retired increments by 1 on the cycle that leaves MEMWB, MEMWR (with mem_ready=1), ALUWB or BRANCH. It wraps modulo 2^CNT_W.
- Latency with mem_ready=1 on first request:
  - R-type 4 cycles, lw 5, sw 4, beq 3.
  - Each mem_ready=0 cycle adds one.
- Handshake rules:
  - MemRead and MemWrite are never asserted together.
  - A request stays asserted with a stable IorD until the cycle mem_ready=1.
  - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset mid-operation (including mid-wait): immediate return to IDLE; all outputs 0 asynchronously.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, ALUWB=8, BRANCH=9, TRAP=15
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ
  - ALUOp, ALUSrcA, ALUSrcB and ResultSrc code constants
- No sub-module. Single-file FSM: next-state block, output decode block, counter block.

Test Plan:
- Reset release, RESET_PC_HOLD=1, opcode=0110011, mem_ready=1 -> state_o sequence 0,1,2,7,8,1. RegWrite=1 only in ALUWB. retired=1 after ALUWB.
- lw (0000011) with mem_ready low 2 cycles in MEMRD -> MemRead=1 and IorD=1 held 3 cycles. Then MEMWB with ResultSrc=01 and RegWrite=1. Total 7 cycles FETCH-to-FETCH.
- sw (0100011), mem_ready=1 -> MEMWR asserts MemWrite=1 for 1 cycle. RegWrite stays 0. retired increments.
- beq (1100011), once with zero=1 and once with zero=0 -> BRANCH drives ALUOp=01 and PCWrite=1/0 respectively. 3 cycles each.
- opcode=0010011 -> DECODE goes to TRAP. halt=1 persists 20 cycles with mem_ready toggling. rst_n pulse clears halt; retired=0.
- Assert rst_n=0 mid-MEMRD wait -> all outputs 0 in the same cycle without a clock edge. state_o=0.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// State, opcode and datapath select encodings shared by the multi-cycle controller and its datapath.
// Pure constants; no logic, no latency.
package mc_ctrl_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC_R = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // lw and sw share the address-calculation state
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory bundle: datapath selects, write enables and the memory req/ready pair.
// master = controller side, slave = datapath/memory side.
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       ALUOp;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [3:0]       state_o;
  logic             halt;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, IorD, MemRead, MemWrite,
           IRWrite, PCWrite, RegWrite, state_o, halt, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, IorD, MemRead, MemWrite,
           IRWrite, PCWrite, RegWrite, state_o, halt, retired
  );

endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: R-type 4, lw 5, sw 4, beq 3 cycles; each mem_ready=0 cycle in a memory
// state adds one. Requests are held with stable IorD until mem_ready; illegal opcodes park in TRAP.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_fsm_if.master bus
);

  logic [3:0]       state, nxt;
  logic [3:0]       hold;
  logic [CNT_W-1:0] retired_q;
  logic             retire_en;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (hold <= 4'd1) nxt = S_FETCH;
      S_FETCH:  if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(bus.opcode))    nxt = S_MEMADR;
        else if (bus.opcode == OP_R)  nxt = S_EXEC_R;
        else if (bus.opcode == OP_BEQ) nxt = S_BRANCH;
        else                          nxt = S_TRAP;
      end
      S_MEMADR: nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) nxt = S_MEMWB;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) nxt = S_FETCH;
      S_EXEC_R: nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      // unused encodings are treated as a corrupted state and trapped
      default:  nxt = S_TRAP;
    endcase
  end

  always_comb begin
    retire_en = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH: retire_en = 1'b1;
      S_MEMWR:                    retire_en = bus.mem_ready;
      default:                    retire_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= RESET_PC_HOLD[3:0];
      retired_q <= '0;
    end else begin
      if (state == S_IDLE && hold != 4'd0) hold <= hold - 4'd1;
      if (retire_en) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    bus.ALUOp     = ALUOP_ADD;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_REGB;
    bus.ResultSrc = RES_ALUOUT;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.halt      = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead   = 1'b1;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ALUOp     = ALUOP_ADD;
        bus.ResultSrc = RES_ALU;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_REGA;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_MDR;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = SRCA_REGA;
        bus.ALUSrcB = SRCB_REGB;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = SRCA_REGA;
        bus.ALUSrcB   = SRCB_REGB;
        bus.ALUOp     = ALUOP_SUB;
        bus.ResultSrc = RES_ALUOUT;
        bus.PCWrite   = bus.zero;
      end
      S_TRAP:  bus.halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.state_o = state;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_control_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.CNT_W(32)) bus ();

  mc_control_fsm #(.CNT_W(32), .RESET_PC_HOLD(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
                         MEMWB = 4'd5, MEMWR = 4'd6, EXEC_R = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
                         TRAP = 4'd15;

  localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011, BEQ = 7'b1100011,
                         ILL = 7'b0010011;

  // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, halt}
  localparam logic [14:0] K_ZERO     = 15'b00_00_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] K_FETCH_W  = 15'b00_00_01_10_0_1_0_0_0_0_0;
  localparam logic [14:0] K_FETCH_R  = 15'b00_00_01_10_0_1_0_1_1_0_0;
  localparam logic [14:0] K_DECODE   = 15'b00_01_10_00_0_0_0_0_0_0_0;
  localparam logic [14:0] K_MEMADR   = 15'b00_10_10_00_0_0_0_0_0_0_0;
  localparam logic [14:0] K_MEMRD    = 15'b00_00_00_00_1_1_0_0_0_0_0;
  localparam logic [14:0] K_MEMWB    = 15'b00_00_00_01_0_0_0_0_0_1_0;
  localparam logic [14:0] K_MEMWR    = 15'b00_00_00_00_1_0_1_0_0_0_0;
  localparam logic [14:0] K_EXEC_R   = 15'b10_10_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] K_ALUWB    = 15'b00_00_00_00_0_0_0_0_0_1_0;
  localparam logic [14:0] K_BR_TAKEN = 15'b01_10_00_00_0_0_0_0_1_0_0;
  localparam logic [14:0] K_BR_NOT   = 15'b01_10_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] K_TRAP     = 15'b00_00_00_00_0_0_0_0_0_0_1;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   step_n = 0;

  logic [14:0] act_ctl;
  assign act_ctl = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.halt};

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, id, act, want);
    end
  endtask

  // One clock window: drive inputs just after the edge and queue what the DUT must show in it.
  task automatic cyc(input logic [6:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [14:0] ctl, input logic [31:0] ret);
    exp_t e;
    @(posedge clk);
    #1;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    step_n++;
    e.id  = step_n;
    e.st  = st;
    e.ctl = ctl;
    e.ret = ret;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("state", e.id, {28'b0, bus.state_o}, {28'b0, e.st});
      check("ctl", e.id, {17'b0, act_ctl}, {17'b0, e.ctl});
      check("retired", e.id, bus.retired, e.ret);
      if (bus.MemRead && bus.MemWrite) begin
        total++;
        bad++;
        $display("FAIL rd_wr_overlap step=%0d", e.id);
      end
    end
  end

  initial begin
    bus.opcode    = 7'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // reset held, then one IDLE hold cycle
    cyc(R, 0, 1, IDLE, K_ZERO, 0);
    cyc(R, 0, 1, IDLE, K_ZERO, 0);
    rst_n = 1'b1;

    // R-type: 0,1,2,7,8,1
    cyc(R, 0, 1, FETCH,  K_FETCH_R, 0);
    cyc(R, 0, 1, DECODE, K_DECODE,  0);
    cyc(R, 0, 1, EXEC_R, K_EXEC_R,  0);
    cyc(R, 0, 1, ALUWB,  K_ALUWB,   0);

    // lw with two wait cycles in MEMRD: 7 cycles FETCH-to-FETCH
    cyc(LW, 0, 1, FETCH,  K_FETCH_R, 1);
    cyc(LW, 0, 1, DECODE, K_DECODE,  1);
    cyc(LW, 0, 1, MEMADR, K_MEMADR,  1);
    cyc(LW, 0, 0, MEMRD,  K_MEMRD,   1);
    cyc(LW, 0, 0, MEMRD,  K_MEMRD,   1);
    cyc(LW, 0, 1, MEMRD,  K_MEMRD,   1);
    cyc(LW, 0, 1, MEMWB,  K_MEMWB,   1);

    // sw with one fetch wait cycle
    cyc(SW, 0, 0, FETCH,  K_FETCH_W, 2);
    cyc(SW, 0, 1, FETCH,  K_FETCH_R, 2);
    cyc(SW, 0, 1, DECODE, K_DECODE,  2);
    cyc(SW, 0, 1, MEMADR, K_MEMADR,  2);
    cyc(SW, 0, 1, MEMWR,  K_MEMWR,   2);

    // beq taken then not taken
    cyc(BEQ, 1, 1, FETCH,  K_FETCH_R,  3);
    cyc(BEQ, 1, 1, DECODE, K_DECODE,   3);
    cyc(BEQ, 1, 1, BRANCH, K_BR_TAKEN, 3);
    cyc(BEQ, 0, 1, FETCH,  K_FETCH_R,  4);
    cyc(BEQ, 0, 1, DECODE, K_DECODE,   4);
    cyc(BEQ, 0, 1, BRANCH, K_BR_NOT,   4);

    // illegal opcode traps; halt persists with mem_ready toggling
    cyc(ILL, 0, 1, FETCH,  K_FETCH_R, 5);
    cyc(ILL, 0, 1, DECODE, K_DECODE,  5);
    for (int i = 0; i < 20; i++) begin
      logic t;
      t = (i % 2) == 0;
      cyc(ILL, 0, t, TRAP, K_TRAP, 5);
    end

    // reset pulse clears halt and retired
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    begin
      exp_t e;
      step_n++;
      e.id = step_n; e.st = IDLE; e.ctl = K_ZERO; e.ret = 0;
      q.push_back(e);
    end
    #1;
    rst_n = 1'b1;

    // lw stalled in MEMRD, then async reset mid-wait
    cyc(LW, 0, 1, FETCH,  K_FETCH_R, 0);
    cyc(LW, 0, 1, DECODE, K_DECODE,  0);
    cyc(LW, 0, 0, MEMADR, K_MEMADR,  0);
    cyc(LW, 0, 0, MEMRD,  K_MEMRD,   0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", -1, {28'b0, bus.state_o}, 32'd0);
    check("async_ctl", -1, {17'b0, act_ctl}, 32'd0);

    // recovery: one more R-type
    cyc(R, 0, 1, IDLE, K_ZERO, 0);
    rst_n = 1'b1;
    cyc(R, 0, 1, FETCH,  K_FETCH_R, 0);
    cyc(R, 0, 1, DECODE, K_DECODE,  0);
    cyc(R, 0, 1, EXEC_R, K_EXEC_R,  0);
    cyc(R, 0, 1, ALUWB,  K_ALUWB,   0);
    cyc(R, 0, 1, FETCH,  K_FETCH_R, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
